// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states, default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_e;

  // Ops that go through the one-bit-per-cycle multiply/divide datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Multiply: {hi,lo} ends as the 2*WIDTH-bit product of a and b.
// Divide:   lo ends as a / b (quotient), hi as a % b (remainder).
// The load cycle already performs the first step, so rdy rises WIDTH-1 cycles after load.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             rdy
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mc_q, mc_d;   // multiplicand or divisor
  logic             div_q, div_d;
  logic             rdy_q, rdy_d;
  logic [CW-1:0]    cnt_q, cnt_d; // steps still to perform

  logic             div_in;
  logic [WIDTH-1:0] hi_in, lo_in, mc_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // One multiply or divide step on either fresh operands (load) or the working registers.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    div_in = div_q;
    hi_in  = hi_q;
    lo_in  = lo_q;
    mc_in  = mc_q;
    if (load) begin
      div_in = is_div_op(op);
      hi_in  = '0;
      lo_in  = div_in ? a : b;
      mc_in  = div_in ? b : a;
    end

    // Shift-add: conditionally add multiplicand to the upper half, then shift the pair right.
    sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, mc_in} : '0);

    // Restoring divide: bring in the next dividend bit, subtract divisor if it fits.
    // A zero divisor always "fits", yielding an all-ones quotient and the dividend as remainder.
    shifted = {hi_in, lo_in[WIDTH-1]};
    ge      = shifted >= {1'b0, mc_in};
    diff    = shifted[WIDTH-1:0] - mc_in;

    hi_d  = hi_q;
    lo_d  = lo_q;
    mc_d  = mc_q;
    div_d = div_q;
    cnt_d = cnt_q;
    rdy_d = rdy_q;

    if (load || (cnt_q != '0)) begin
      if (div_in) begin
        hi_d = ge ? diff : shifted[WIDTH-1:0];
        lo_d = {lo_in[WIDTH-2:0], ge};
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_in[WIDTH-1:1]};
      end
      mc_d  = mc_in;
      div_d = div_in;
    end

    if (load) begin
      cnt_d = CW'(WIDTH - 1);
      rdy_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      rdy_d = (cnt_q == CW'(1));
    end
  end

  // Working registers, cleared by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      mc_q  <= '0;
      div_q <= 1'b0;
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mc_q  <= mc_d;
      div_q <= div_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
    end
  end

  assign hi  = hi_q;
  assign lo  = lo_q;
  assign rdy = rdy_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative mul/div.
// Single-cycle ops complete at the next edge; iterative ops hold busy for WIDTH
// cycles and then pulse done from the FIN state. start is accepted in IDLE and FIN.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             dz
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic [3:0]       op_q, op_d;   // iterative op in flight
  logic             bz_q, bz_d;   // divisor of the op in flight was zero

  logic             md_load;
  logic [WIDTH-1:0] md_hi, md_lo, md_res;
  logic             md_rdy;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   sh;

  assign sh = a[SHW-1:0];

  alu_muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk  (clk),
    .rstn (rstn),
    .load (md_load),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi   (md_hi),
    .lo   (md_lo),
    .rdy  (md_rdy)
  );

  // Low half for MUL/DIVU, high half for MULHU/REMU.
  assign md_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? md_lo : md_hi;

  // Single-cycle operations; undefined op codes fall through to NOP.
  always_comb begin
    alu_res = a;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  alu_res = b << sh;
      OP_SRL:  alu_res = b >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(b) >>> sh);
      default: alu_res = a;
    endcase
  end

  // FSM next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    op_d     = op_q;
    bz_d     = bz_q;
    md_load  = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          if (is_iter_op(op)) begin
            state_d = ITER;
            cnt_d   = SHW'(WIDTH - 1);
            busy_d  = 1'b1;
            op_d    = op;
            bz_d    = (b == '0);
            md_load = 1'b1;
          end else begin
            done_d   = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            dz_d     = 1'b0;
          end
        end
      end
      ITER: begin
        if ((cnt_q == '0) && md_rdy) begin
          state_d  = FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = md_res;
          zero_d   = (md_res == '0);
          dz_d     = bz_q && is_div_op(op_q);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      dz_q     <= 1'b0;
      op_q     <= OP_NOP;
      bz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
      op_q     <= op_d;
      bz_q     <= bz_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table plus multi-cycle corner sequences.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 200;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         dz;

  int checks    = 0;
  int failures  = 0;
  int inject_at = -1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .dz     (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] r, input logic z, input logic d);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.zero = z; v.dz = d;
    vecs.push_back(v);
  endfunction

  // Present a request at a falling edge; it is taken at the following rising edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  // Wait (bounded) for done; scribbles the inputs meanwhile to prove operand capture.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == inject_at) begin
        start = 1'b1; op = OP_ADD; a = 1; b = 1;
      end else begin
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
      end
      if (busy && !done) bcnt++;
    end while (!done && lat < TMO);
  endtask

  int lat, bcnt, ndone;
  bit iter;

  initial begin
    rstn = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0;

    add(OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0);
    add(OP_SRA,   32'h4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0);
    add(OP_SLL,   32'h21,       32'h1,        32'h2,        1'b0, 1'b0);
    add(OP_SUB,   32'h5,        32'h5,        32'h0,        1'b1, 1'b0);
    add(OP_NOP,   32'h1234,     32'hFFFF,     32'h1234,     1'b0, 1'b0);
    add(OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
    add(OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
    add(OP_SLT,   32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
    add(OP_SRL,   32'h24,       32'hF0000000, 32'h0F000000, 1'b0, 1'b0);
    add(OP_SRA,   32'h3F,       32'h7FFFFFFF, 32'h0,        1'b1, 1'b0);
    add(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    add(OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    add(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    add(4'd15,    32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 1'b0, 1'b0);
    add(OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
    add(OP_SUB,   32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0);
    add(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0);
    add(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    add(OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
    add(OP_REMU,  32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
    add(OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1'b1);
    add(OP_REMU,  32'd100,      32'd0,        32'd100,      1'b0, 1'b1);
    add(OP_MUL,   32'd12345,    32'd1000,     32'd12345000, 1'b0, 1'b0);
    add(OP_MULHU, 32'h80000000, 32'h4,        32'h2,        1'b0, 1'b0);
    add(OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0, 1'b0);
    add(OP_REMU,  32'hFFFFFFFF, 32'h10,       32'hF,        1'b0, 1'b0);
    add(OP_REMU,  32'd5,        32'd9,        32'd5,        1'b0, 1'b0);

    // Reset state
    #2 rstn = 1'b0;
    #5;
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zero",   64'(zero),   64'(1));
    check("rst_dz",     64'(dz),     64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      iter = (vecs[i].op >= OP_MUL) && (vecs[i].op <= OP_REMU);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i),   64'(lat),    iter ? 64'(W + 1) : 64'(1));
      check($sformatf("v%0d_busy_cyc", i),  64'(bcnt),   iter ? 64'(W) : 64'(0));
      check($sformatf("v%0d_busy_done", i), 64'(busy),   64'(0));
      check($sformatf("v%0d_result", i),    64'(result), 64'(vecs[i].res));
      check($sformatf("v%0d_zero", i),      64'(zero),   64'(vecs[i].zero));
      check($sformatf("v%0d_dz", i),        64'(dz),     64'(vecs[i].dz));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'(0));
    end

    // start during busy is ignored and not queued
    issue(OP_MUL, 32'd3, 32'd5);
    inject_at = 5;
    wait_done(lat, bcnt);
    inject_at = -1;
    check("ign_latency", 64'(lat),    64'(W + 1));
    check("ign_result",  64'(result), 64'(15));
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_no_queue", 64'(ndone),  64'(0));
    check("ign_hold",     64'(result), 64'(15));
    check("ign_zero",     64'(zero),   64'(0));

    // back-to-back start in the done cycle
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    check("b2b_div_result", 64'(result), 64'(14));
    start = 1'b1; op = OP_ADD; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_add_done",   64'(done),   64'(1));
    check("b2b_add_result", 64'(result), 64'(5));
    check("b2b_add_busy",   64'(busy),   64'(0));

    // reset in the middle of a divide
    issue(OP_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", 64'(busy), 64'(1));
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_busy",   64'(busy),   64'(0));
    check("mid_rst_done",   64'(done),   64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    check("mid_rst_zero",   64'(zero),   64'(1));
    check("mid_rst_dz",     64'(dz),     64'(0));
    @(negedge clk);
    check("mid_rst_hold_done", 64'(done), 64'(0));
    rstn = 1'b1;
    start = 1'b1; op = OP_ADD; a = 32'd10; b = 32'd20;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_done",   64'(done),   64'(1));
    check("post_rst_result", 64'(result), 64'(30));
    check("post_rst_zero",   64'(zero),   64'(0));
    ndone = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("post_rst_quiet", 64'(ndone),  64'(0));
    check("post_rst_hold",  64'(result), 64'(30));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
